// File: rtl/app_pkg.sv
// app_pkg: constants shared by the stream application blocks.
//   - Mode encodings for the VCR app_mode register.
//   - Bit positions inside the app_status word.
//   - mode_supported(): true for the mode codes this engine implements.
package app_pkg;

    localparam logic [7:0] MODE_PASS     = 8'd0;
    localparam logic [7:0] MODE_THROTTLE = 8'd1;
    localparam logic [7:0] MODE_INVPKT   = 8'd2;
    localparam logic [7:0] MODE_GEN      = 8'd3;

    localparam int ST_UNSUPPORTED = 0;
    localparam int ST_HOLD_VALID  = 1;
    localparam int ST_FULL_STALL  = 2;
    localparam int ST_THR_MISS    = 3;
    localparam int ST_MODE_LSB    = 4;

    function automatic logic mode_supported(input logic [7:0] mode);
        return (mode[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/app_stream_engine_if.sv
// app_stream_engine_if: FIFO-side bus of a stream application block.
//   din/empty/rd_en : first-word-fall-through input FIFO (din valid when ~empty)
//   dout/wr_en/full : output FIFO push side
//   pkt_end         : packet-end marker travelling with dout, qualified by wr_en
// Modports:
//   master : the application engine
//   slave  : the FIFO pair surrounding it
interface app_stream_engine_if #(
    parameter int DW = 64
);
    logic [DW-1:0] din;
    logic          empty;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          wr_en;
    logic          full;
    logic          pkt_end;

    modport master (
        input  din, empty, full,
        output rd_en, dout, wr_en, pkt_end
    );

    modport slave (
        output din, empty, full,
        input  rd_en, dout, wr_en, pkt_end
    );
endinterface

// File: rtl/app_hold_stage.sv
// app_hold_stage: single-entry registered output buffer.
//   CLK, RESET_N  : clock, asynchronous active-low reset
//   load          : request to capture load_data/load_pkt_end (honoured only when can_load)
//   load_data     : word to hold
//   load_pkt_end  : packet-end flag stored alongside the word
//   full          : downstream FIFO full
//   can_load      : buffer empty or draining this cycle
//   wr_en         : downstream push (valid held word and room downstream)
//   hold_valid    : buffer occupied
//   dout, pkt_end : held word and its packet-end flag
// A load on the same edge as a write replaces the outgoing word, giving
// one word per cycle with no bubble.
module app_hold_stage #(
    parameter int DW = 64
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_pkt_end,
    input  logic          full,
    output logic          can_load,
    output logic          wr_en,
    output logic          hold_valid,
    output logic [DW-1:0] dout,
    output logic          pkt_end
);

    assign wr_en    = hold_valid & ~full;
    assign can_load = ~hold_valid | wr_en;

    // holding register stage
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_valid <= 1'b0;
            dout       <= '0;
            pkt_end    <= 1'b0;
        end else if (load && can_load) begin
            hold_valid <= 1'b1;
            dout       <= load_data;
            pkt_end    <= load_pkt_end;
        end else if (wr_en) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/app_stream_engine.sv
// app_stream_engine: moves words from the input FIFO to the output FIFO
// through one holding register, under a VCR-selected mode.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus          : FIFO-side stream bus (master modport)
//   app_mode     : requested mode (0 pass, 1 throttle, 2 invert/packetise, 3 generator)
//   app_status   : [0] unsupported mode, [1] hold_valid, [2] sticky full stall,
//                  [3] sticky throttle slot missed on empty, [7:4] active mode
// Parameters: DW word width, PKT_WORDS words per packet (modes 2/3),
// THROTTLE cycles per word (mode 1), CW generator/counter width.
module app_stream_engine
    import app_pkg::*;
#(
    parameter int DW        = 64,
    parameter int PKT_WORDS = 16,
    parameter int THROTTLE  = 16,
    parameter int CW        = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    app_stream_engine_if.master bus,
    input  logic [7:0]          app_mode,
    output logic [7:0]          app_status
);

    localparam int TW = (THROTTLE  > 1) ? $clog2(THROTTLE)  : 1;
    localparam int WW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [TW-1:0] THR_LAST = TW'(THROTTLE - 1);
    localparam logic [WW-1:0] WC_LAST  = WW'(PKT_WORDS - 1);

    logic [7:0]    mode_r;
    logic [WW-1:0] word_cnt;
    logic [TW-1:0] thr_cnt;
    logic [CW-1:0] gen_cnt;
    logic          sticky_full;
    logic          sticky_miss;

    logic          can_load;
    logic          wr_en;
    logic          hold_valid;
    logic [DW-1:0] dout;
    logic          pkt_end;

    logic          mode_change;
    logic          thr_slot;
    logic          pkt_last;
    logic          rd_en;
    logic          load_p0;
    logic [DW-1:0] ld_data_p0;
    logic          ld_pkt_end_p0;

    // A mode change takes the slot in which a load could have happened, so
    // no word is ever loaded under one mode and counted under another.
    assign mode_change = can_load && (app_mode != mode_r);
    assign thr_slot    = (thr_cnt == THR_LAST);
    assign pkt_last    = (word_cnt == WC_LAST);

    // load selection stage
    always_comb begin
        rd_en         = 1'b0;
        load_p0       = 1'b0;
        ld_data_p0    = '0;
        ld_pkt_end_p0 = 1'b0;
        if (RESET_N && can_load && !mode_change) begin
            case (mode_r)
                MODE_PASS: begin
                    if (!bus.empty) begin
                        rd_en         = 1'b1;
                        load_p0       = 1'b1;
                        ld_data_p0    = bus.din;
                        ld_pkt_end_p0 = 1'b1;
                    end
                end
                MODE_THROTTLE: begin
                    if (!bus.empty && thr_slot) begin
                        rd_en         = 1'b1;
                        load_p0       = 1'b1;
                        ld_data_p0    = bus.din;
                        ld_pkt_end_p0 = 1'b1;
                    end
                end
                MODE_INVPKT: begin
                    if (!bus.empty) begin
                        rd_en         = 1'b1;
                        load_p0       = 1'b1;
                        ld_data_p0    = ~bus.din;
                        ld_pkt_end_p0 = pkt_last;
                    end
                end
                MODE_GEN: begin
                    load_p0       = 1'b1;
                    ld_data_p0    = DW'(gen_cnt);
                    ld_pkt_end_p0 = pkt_last;
                end
                default: ;
            endcase
        end
    end

    // control registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_r      <= '0;
            word_cnt    <= '0;
            thr_cnt     <= '0;
            gen_cnt     <= '0;
            sticky_full <= 1'b0;
            sticky_miss <= 1'b0;
        end else begin
            if (mode_change) begin
                mode_r   <= app_mode;
                word_cnt <= '0;
                thr_cnt  <= '0;
            end else begin
                thr_cnt <= thr_slot ? '0 : thr_cnt + 1'b1;
                if (load_p0 && (mode_r == MODE_INVPKT || mode_r == MODE_GEN))
                    word_cnt <= pkt_last ? '0 : word_cnt + 1'b1;
            end
            // generator value survives mode changes; only reset clears it
            if (load_p0 && mode_r == MODE_GEN)
                gen_cnt <= gen_cnt + 1'b1;
            if (hold_valid && bus.full)
                sticky_full <= 1'b1;
            if (!mode_change && mode_r == MODE_THROTTLE && thr_slot && bus.empty)
                sticky_miss <= 1'b1;
        end
    end

    app_hold_stage #(.DW(DW)) u_hold (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .load         (load_p0),
        .load_data    (ld_data_p0),
        .load_pkt_end (ld_pkt_end_p0),
        .full         (bus.full),
        .can_load     (can_load),
        .wr_en        (wr_en),
        .hold_valid   (hold_valid),
        .dout         (dout),
        .pkt_end      (pkt_end)
    );

    assign bus.rd_en   = rd_en;
    assign bus.wr_en   = wr_en;
    assign bus.dout    = dout;
    assign bus.pkt_end = pkt_end;

    always_comb begin
        app_status                              = '0;
        app_status[ST_UNSUPPORTED]              = ~mode_supported(mode_r);
        app_status[ST_HOLD_VALID]               = hold_valid;
        app_status[ST_FULL_STALL]               = sticky_full;
        app_status[ST_THR_MISS]                 = sticky_miss;
        app_status[ST_MODE_LSB+3:ST_MODE_LSB]   = mode_r[3:0];
    end

endmodule

// File: tb/tb_app_stream_engine.sv
module tb_app_stream_engine;
    import app_pkg::*;

    localparam int DW = 64;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] app_mode;
    logic [7:0] app_status;

    app_stream_engine_if #(.DW(DW)) sif ();

    app_stream_engine #(
        .DW(DW), .PKT_WORDS(4), .THROTTLE(16), .CW(16)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .bus        (sif),
        .app_mode   (app_mode),
        .app_status (app_status)
    );

    always #5 CLK = ~CLK;

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] src_q[$];
    int            rd_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        src_q.push_back(w);
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic pe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge CLK);
            n++;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // input FIFO model: pop decided by rd_en seen before the edge
    initial begin
        logic p;
        int   c;
        sif.din   = '0;
        sif.empty = 1'b1;
        forever begin
            @(negedge CLK);
            p = sif.rd_en;
            c = cyc;
            @(posedge CLK);
            #2;
            if (p && src_q.size() != 0) begin
                void'(src_q.pop_front());
                rd_log.push_back(c);
            end
            sif.din   = (src_q.size() != 0) ? src_q[0] : '0;
            sif.empty = (src_q.size() == 0);
        end
    end

    // scoreboard monitor
    initial forever begin
        exp_t e;
        @(negedge CLK);
        if (sif.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected none", sif.dout);
            end else begin
                e = exp_q.pop_front();
                chk("sb_dout", sif.dout, e.d);
                chk("sb_pkt_end", 64'(sif.pkt_end), 64'(e.pe));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        RESET_N  = 1'b0;
        app_mode = 8'd0;
        sif.full = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wr_en", 64'(sif.wr_en), 0);
        chk("rst_rd_en", 64'(sif.rd_en), 0);
        chk("rst_dout", sif.dout, 0);
        chk("rst_pkt_end", 64'(sif.pkt_end), 0);
        chk("rst_status", 64'(app_status), 0);
        RESET_N = 1'b1;

        // mode 0 passthrough, 8 words
        @(posedge CLK);
        #1;
        rd_log.delete();
        t0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            push_word(64'(i));
            push_exp(64'(i), 1'b1);
        end
        drain("pass_drain");
        chk("pass_rd_count", 64'(rd_log.size()), 8);
        if (rd_log.size() == 8) begin
            chk("pass_rd_first", 64'(rd_log[0]), 64'(t0));
            chk("pass_rd_contig", 64'(rd_log[7]), 64'(t0 + 7));
        end

        // mode 1 throttle, 10 words
        app_mode = MODE_THROTTLE;
        rd_log.delete();
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            push_word(64'h100 + 64'(i));
            push_exp(64'h100 + 64'(i), 1'b1);
        end
        repeat (180) @(posedge CLK);
        #1;
        chk("thr_rd_count", 64'(rd_log.size()), 10);
        for (int i = 0; i < 10; i++)
            if (i < rd_log.size())
                chk("thr_rd_slot", 64'(rd_log[i]), 64'(t0 + 16 * (i + 1)));
        chk("thr_exp_empty", 64'(exp_q.size()), 0);
        chk("thr_status", 64'(app_status), 64'h18);

        // mode 2 invert/packetise, 12 words
        app_mode = MODE_INVPKT;
        for (int i = 0; i < 12; i++) begin
            push_word(64'(i));
            push_exp(~64'(i), (i % 4) == 3);
        end
        drain("inv_drain");

        // mode 3 generator with 5-cycle full stall
        app_mode = MODE_GEN;
        for (int i = 0; i < 10; i++)
            push_exp(64'(i), (i % 4) == 3);
        repeat (4) @(posedge CLK);
        #1;
        sif.full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_dout", sif.dout, 2);
            chk("stall_wr_en", 64'(sif.wr_en), 0);
            @(posedge CLK);
        end
        #1;
        sif.full = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        sif.full = 1'b1;
        app_mode = 8'hFF;
        @(negedge CLK);
        chk("gen_hold_dout", sif.dout, 9);
        chk("gen_status", 64'(app_status), 64'h3E);
        @(posedge CLK);
        #1;
        sif.full = 1'b0;
        drain("gen_drain");
        chk("unsup_status", 64'(app_status), 64'hFD);

        // switch 0 -> 2 while a mode-0 word is held behind full
        app_mode = MODE_PASS;
        sif.full = 1'b1;
        push_word(64'hA5);
        push_exp(64'hA5, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        chk("sw_held_dout", sif.dout, 64'hA5);
        chk("sw_held_wr_en", 64'(sif.wr_en), 0);
        chk("sw_held_status", 64'(app_status), 64'h0E);
        app_mode = MODE_INVPKT;
        for (int i = 0; i < 4; i++) begin
            push_word(64'h10 + 64'(i));
            push_exp(~(64'h10 + 64'(i)), i == 3);
        end
        repeat (2) @(posedge CLK);
        #1;
        chk("sw_stall_rd_en", 64'(sif.rd_en), 0);
        chk("sw_stall_status", 64'(app_status), 64'h0E);
        sif.full = 1'b0;
        drain("sw_drain");
        chk("sw_status", 64'(app_status), 64'h2C);

        // reset mid-packet in mode 2
        for (int i = 0; i < 7; i++)
            push_word(64'h20 + 64'(i));
        push_exp(~64'h20, 1'b0);
        push_exp(~64'h21, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("midrst_wr_en", 64'(sif.wr_en), 0);
        chk("midrst_rd_en", 64'(sif.rd_en), 0);
        chk("midrst_dout", sif.dout, 0);
        chk("midrst_status", 64'(app_status), 0);
        @(posedge CLK);
        #1;
        chk("midrst_hold_rd_en", 64'(sif.rd_en), 0);
        RESET_N = 1'b1;
        for (int i = 3; i < 7; i++)
            push_exp(~(64'h20 + 64'(i)), i == 6);
        drain("rst_drain");
        chk("rst_final_status", 64'(app_status), 64'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/app_stream_engine.md
Name: app_stream_engine

Overview:
- Parametrised successor of the loopback application block; sits between the high-speed interface input FIFO (din side) and output FIFO (dout side).
- Moves words from input to output through one registered holding stage under VCR-selected modes: passthrough, throttled, inverting packetiser, test-pattern generator.
- Drives packet boundaries (pkt_end) and reports live and sticky status on app_status.

Parameters:
DW, 64, data word width (bits), >=8
PKT_WORDS, 16, words per packet in modes 2 and 3, >=1
THROTTLE, 16, cycles per accepted word in mode 1, >=2
CW, 16, generator/word-counter width, <=DW

Ports:
CLK  input  1  system clock
RESET_N  input  1  asynchronous active-low reset
din  input  DW  input FIFO data (first-word-fall-through, valid when ~empty)
rd_en  output  1  input FIFO pop (combinational)
empty  input  1  input FIFO empty
dout  output  DW  output FIFO data (registered)
wr_en  output  1  output FIFO push (combinational from registered valid)
full  input  1  output FIFO full
pkt_end  output  1  packet-end marker qualified by wr_en (registered with dout)
app_mode  input  8  VCR mode select
app_status  output  8  VCR status

Behaviour:
- Reset (RESET_N low, async assert, sync release in the clock domain): hold_valid=0, dout=0, pkt_end=0, mode_r=0, word_cnt=0, thr_cnt=0, gen_cnt=0, sticky bits=0. Hence rd_en=0, wr_en=0, app_status=0.
- Holding stage: hold_valid, dout, pkt_end registers.
  - wr_en = hold_valid & ~full.
  - can_load = ~hold_valid | wr_en. Back-to-back throughput is 1 word/cycle.
- Mode latch: mode_r <= app_mode only when can_load & no load this cycle is in progress from the old mode, i.e. on any cycle where hold_valid==0 or wr_en==1. On change, word_cnt and thr_cnt clear in that same cycle. A held word always drains with the mode it was loaded under.
- Mode 0 (passthrough):
  - rd_en = can_load & ~empty.
  - Load dout<=din, pkt_end<=1.
  - Latency: din popped in cycle N appears with wr_en in N+1 (if ~full).
- Mode 1 (throttle):
  - thr_cnt is free-running 0..THROTTLE-1 with wrap.
  - rd_en = can_load & ~empty & (thr_cnt==THROTTLE-1).
  - If the slot is missed (empty/full), wait for the next wrap; no catch-up.
  - pkt_end<=1.
- Mode 2 (invert/packetise):
  - rd_en = can_load & ~empty.
  - Load dout<=~din, pkt_end<=(word_cnt==PKT_WORDS-1).
  - word_cnt increments per load and wraps to 0 after PKT_WORDS-1.
- Mode 3 (generator):
  - rd_en=0; a load occurs whenever can_load.
  - dout<=zero-extended gen_cnt; gen_cnt increments mod 2^CW per load.
  - pkt_end and word_cnt behave as in mode 2.
  - gen_cnt is not cleared on mode change, only by reset.
- Other modes: rd_en=0, no loads, held word still drains; status bit 0 set.
- Simultaneous load and write: the new word replaces the old in the same edge; no bubble.
- full held indefinitely: dout/pkt_end/hold_valid stable, rd_en=0.
- Reset mid-packet: word_cnt restarts at 0, and the held word is discarded.
- app_status:
  - [0] mode_r unsupported (live)
  - [1] hold_valid (live)
  - [2] sticky: wr stalled by full at least once
  - [3] sticky: mode 1 slot missed due to empty
  - [7:4] mode_r[3:0]

Decomposition:
- Shared package app_pkg:
  - mode constants MODE_PASS=0, MODE_THROTTLE=1, MODE_INVPKT=2, MODE_GEN=3
  - app_status bit index constants
- One natural sub-module: app_hold_stage (single-entry registered buffer with can_load/wr_en handshake, DW-parametrised), reusable by later applications.

Test Plan:
- Mode 0, empty=0, full=0, din=N per cycle for 8 words -> wr_en high from cycle 1, dout sequence identical, pkt_end=1 every word, rd_en continuous.
- Mode 1, THROTTLE=16, input always available -> exactly one rd_en per 16 cycles, wr_en one cycle later, 10 words in 160 cycles.
- Mode 2, PKT_WORDS=4, din=0x0,0x1,... -> dout=0xFFFF_FFFF_FFFF_FFFF,...FFFE,...; pkt_end on the 4th, 8th, 12th writes only.
- Mode 3 with full asserted for 5 cycles mid-stream -> dout frozen during the stall, gen_cnt sequence gap-free 0,1,2..., app_status[2]=1 afterwards.
- Switch app_mode 0->2 while hold_valid=1 and full=1 -> pending word drains with pkt_end=1, first mode-2 word inverted, word_cnt starts at 0.
- RESET_N pulsed low mid-packet in mode 2 -> wr_en, rd_en, dout, app_status go to 0 asynchronously; after release, packet count restarts at 0.
